simon_button_encoder: RTL and testbench

//   Upstream input stage of the Simon game. Turns four raw, bouncing, asynchronous

---
 rtl/simon_button_encoder.sv | 123 ++++++++++++
 tb/tb_simon_button_encoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/simon_button_encoder.sv
// Simon game input stage: synchronises, debounces and encodes four player buttons,
// emitting one press pulse per accepted single-button press and locking out input.
module simon_button_encoder #(
  parameter int unsigned DEBOUNCE_TICKS = 3,
  parameter int unsigned CNT_W          = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  input  logic       simon_turn,
  input  logic       game_over,
  output logic [1:0] player_num,
  output logic       player_pressed,
  output logic [3:0] btn_held,
  output logic       multi_press
);

  typedef enum logic [1:0] {StLocked, StIdle, StWaitRel} state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [3:0]       s1_q, s2_q;
  logic [3:0]       stable_d, stable_q;
  logic [CNT_W-1:0] cnt_d [4];
  logic [CNT_W-1:0] cnt_q [4];
  state_e           state_d, state_q;
  logic [1:0]       player_num_d, player_num_q;
  logic             player_pressed_d, player_pressed_q;
  logic             multi_press_d, multi_press_q;
  logic             lock;
  logic [1:0]       btn_idx;

  assign lock = simon_turn | game_over;

  // A single matching cycle restarts the count, so only an unbroken run is accepted.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    btn_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (stable_q[i]) begin
        btn_idx = 2'(i);
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    player_num_d     = player_num_q;
    player_pressed_d = 1'b0;
    multi_press_d    = 1'b0;
    case (state_q)
      StLocked: begin
        if (!lock && (stable_q == '0)) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        // Lock takes priority over a press that becomes stable on the same cycle.
        if (lock) begin
          state_d = StLocked;
        end else if ($onehot(stable_q)) begin
          state_d          = StWaitRel;
          player_num_d     = btn_idx;
          player_pressed_d = 1'b1;
        end else if (stable_q != '0) begin
          state_d       = StWaitRel;
          multi_press_d = 1'b1;
        end
      end
      StWaitRel: begin
        if (stable_q == '0) begin
          state_d = lock ? StLocked : StIdle;
        end
      end
      default: state_d = StLocked;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q             <= '0;
      s2_q             <= '0;
      stable_q         <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      state_q          <= StLocked;
      player_num_q     <= '0;
      player_pressed_q <= 1'b0;
      multi_press_q    <= 1'b0;
    end else begin
      s1_q             <= btn_raw;
      s2_q             <= s1_q;
      stable_q         <= stable_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q          <= state_d;
      player_num_q     <= player_num_d;
      player_pressed_q <= player_pressed_d;
      multi_press_q    <= multi_press_d;
    end
  end

  assign player_num     = player_num_q;
  assign player_pressed = player_pressed_q;
  assign btn_held       = stable_q;
  assign multi_press    = multi_press_q;

endmodule

// File: tb/tb_simon_button_encoder.sv
// Directed bench for simon_button_encoder: expected press events are queued when a
// button is driven and popped whenever the DUT emits player_pressed or multi_press.
module tb_simon_button_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic       simon_turn;
  logic       game_over;
  logic [1:0] player_num;
  logic       player_pressed;
  logic [3:0] btn_held;
  logic       multi_press;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;
  // Event encoding: 0..3 = single press of that button, 4 = multi-press rejection.
  int exp_q[$];

  simon_button_encoder #(
    .DEBOUNCE_TICKS(3),
    .CNT_W         (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .simon_turn    (simon_turn),
    .game_over     (game_over),
    .player_num    (player_num),
    .player_pressed(player_pressed),
    .btn_held      (btn_held),
    .multi_press   (multi_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge and score any pulse.
  task automatic tick();
    int e;
    @(posedge clk);
    #1;
    if (player_pressed || multi_press) begin
      pulses++;
      check("pulse_exclusive", 32'(player_pressed & multi_press), 32'd0);
      check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pulse_event", multi_press ? 32'd4 : 32'(player_num), 32'(e));
      end
    end
  endtask

  task automatic release_wait();
    btn_raw = '0;
    repeat (8) tick();
  endtask

  initial begin
    reset      = 1'b1;
    btn_raw    = '0;
    simon_turn = 1'b0;
    game_over  = 1'b0;
    #1;
    check("rst_num", 32'(player_num), 32'd0);
    check("rst_pressed", 32'(player_pressed), 32'd0);
    check("rst_held", 32'(btn_held), 32'd0);
    check("rst_multi", 32'(multi_press), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) tick();

    // 1: single press latency, btn2
    btn_raw = 4'b0100;
    exp_q.push_back(2);
    p0 = pulses;
    repeat (4) tick();
    check("t1_held_e4", 32'(btn_held), 32'h0);
    tick();
    check("t1_held_e5", 32'(btn_held), 32'h4);
    check("t1_pressed_e5", 32'(player_pressed), 32'd0);
    tick();
    check("t1_pressed_e6", 32'(player_pressed), 32'd1);
    check("t1_num", 32'(player_num), 32'd2);
    tick();
    check("t1_pressed_e7", 32'(player_pressed), 32'd0);
    repeat (3) tick();
    release_wait();
    check("t1_pulses", 32'(pulses - p0), 32'd1);

    // 2: bouncing btn0 then steady
    p0 = pulses;
    btn_raw = 4'b0001; tick();
    btn_raw = 4'b0000; tick();
    btn_raw = 4'b0001; tick();
    btn_raw = 4'b0000; tick();
    check("t2_no_pulse_bounce", 32'(pulses - p0), 32'd0);
    btn_raw = 4'b0001;
    exp_q.push_back(0);
    repeat (5) tick();
    check("t2_pressed_e5", 32'(player_pressed), 32'd0);
    tick();
    check("t2_pressed_e6", 32'(player_pressed), 32'd1);
    check("t2_num", 32'(player_num), 32'd0);
    repeat (4) tick();
    release_wait();
    check("t2_pulses", 32'(pulses - p0), 32'd1);

    // Boundary: a glitch one cycle shorter than the debounce window is rejected
    p0 = pulses;
    btn_raw = 4'b0001;
    repeat (2) tick();
    btn_raw = 4'b0000;
    repeat (8) tick();
    check("glitch_no_pulse", 32'(pulses - p0), 32'd0);

    // 3: btn3 held through lock gives nothing; fresh press afterwards does
    p0 = pulses;
    simon_turn = 1'b1;
    tick();
    btn_raw = 4'b1000;
    repeat (8) tick();
    check("t3_held_locked", 32'(btn_held), 32'h8);
    simon_turn = 1'b0;
    repeat (6) tick();
    check("t3_no_pulse_lock", 32'(pulses - p0), 32'd0);
    release_wait();
    btn_raw = 4'b1000;
    exp_q.push_back(3);
    repeat (8) tick();
    check("t3_num", 32'(player_num), 32'd3);
    release_wait();
    check("t3_pulses", 32'(pulses - p0), 32'd1);

    // 4: two buttons together are rejected
    p0 = pulses;
    btn_raw = 4'b0110;
    exp_q.push_back(4);
    repeat (6) tick();
    check("t4_multi_e6", 32'(multi_press), 32'd1);
    check("t4_pressed_e6", 32'(player_pressed), 32'd0);
    check("t4_num_kept", 32'(player_num), 32'd3);
    tick();
    check("t4_multi_e7", 32'(multi_press), 32'd0);
    release_wait();
    btn_raw = 4'b0010;
    exp_q.push_back(1);
    repeat (8) tick();
    check("t4_num", 32'(player_num), 32'd1);
    release_wait();
    check("t4_pulses", 32'(pulses - p0), 32'd2);

    // 5: long hold, then asynchronous reset in WAIT_REL
    p0 = pulses;
    btn_raw = 4'b0010;
    exp_q.push_back(1);
    repeat (200) tick();
    check("t5_pulses", 32'(pulses - p0), 32'd1);
    check("t5_held", 32'(btn_held), 32'h2);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_num", 32'(player_num), 32'd0);
    check("t5_rst_held", 32'(btn_held), 32'd0);
    check("t5_rst_pressed", 32'(player_pressed), 32'd0);
    check("t5_rst_multi", 32'(multi_press), 32'd0);
    btn_raw = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (8) tick();
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // 6: lock arrives on the same edge btn2 becomes stable
    btn_raw = 4'b1000;
    exp_q.push_back(3);
    repeat (8) tick();
    release_wait();
    p0 = pulses;
    btn_raw = 4'b0100;
    repeat (5) tick();
    check("t6_held_e5", 32'(btn_held), 32'h4);
    simon_turn = 1'b1;
    tick();
    check("t6_pressed_e6", 32'(player_pressed), 32'd0);
    check("t6_num_kept", 32'(player_num), 32'd3);
    tick();
    check("t6_pressed_e7", 32'(player_pressed), 32'd0);
    simon_turn = 1'b0;
    repeat (5) tick();
    release_wait();
    check("t6_pulses", 32'(pulses - p0), 32'd0);
    check("t6_num_final", 32'(player_num), 32'd3);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
